clken_sched: RTL and testbench



---
 rtl/clken_sched.sv | 122 ++++++++++++
 tb/tb_clken_sched.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/clken_sched.sv
// Clock-enable scheduler: divides the board clock into a one-cycle clken strobe,
// sequences the datapath reset and switches divisors only on period boundaries.
module clken_sched #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 3,
  parameter int HOLD_PULSES = 16
) (
  input  logic             fullclock,
  input  logic             reset,
  input  logic             div_req_valid,
  input  logic [WIDTH-1:0] div_req_value,
  output logic             div_req_ready,
  output logic [WIDTH-1:0] active_div,
  output logic             clken,
  output logic             dp_reset,
  output logic             running
);

  localparam logic [WIDTH-1:0] RESET_DIV = (DEFAULT_DIV == 0) ? WIDTH'(1) : WIDTH'(DEFAULT_DIV);
  localparam int HOLD_W = (HOLD_PULSES < 2) ? 1 : $clog2(HOLD_PULSES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_PULSES - 1);

  typedef enum logic [1:0] {S_HOLD, S_RUN, S_DRAIN} state_t;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  cnt_reg, cnt_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [WIDTH-1:0]  pending_reg, pending_next;
  logic [WIDTH-1:0]  div_reg, div_next;
  logic              clken_reg, clken_next;
  logic              dp_reset_reg, dp_reset_next;
  logic              ready_reg, ready_next;
  logic              running_reg, running_next;

  logic              period_end;
  logic [WIDTH-1:0]  req_clamped;

  assign period_end  = (cnt_reg == div_reg - WIDTH'(1));
  assign req_clamped = (div_req_value == '0) ? WIDTH'(1) : div_req_value;

  always_comb begin
    state_next    = state_reg;
    cnt_next      = period_end ? '0 : cnt_reg + WIDTH'(1);
    clken_next    = period_end;
    hold_cnt_next = hold_cnt_reg;
    pending_next  = pending_reg;
    div_next      = div_reg;
    dp_reset_next = dp_reset_reg;
    ready_next    = ready_reg;
    running_next  = running_reg;

    case (state_reg)
      S_HOLD: begin
        if (clken_reg) begin
          if (hold_cnt_reg == HOLD_LAST) begin
            state_next    = S_RUN;
            hold_cnt_next = '0;
            dp_reset_next = 1'b0;
            ready_next    = 1'b1;
            running_next  = 1'b1;
          end else begin
            hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
          end
        end
      end
      S_RUN: begin
        if (div_req_valid && ready_reg) begin
          pending_next = req_clamped;
          state_next   = S_DRAIN;
          ready_next   = 1'b0;
          running_next = 1'b0;
        end
      end
      S_DRAIN: begin
        // The old period just ended; restart the counter phase-aligned so the
        // first new strobe lands exactly pending cycles after the last old one.
        if (clken_reg) begin
          div_next      = pending_reg;
          cnt_next      = (pending_reg == WIDTH'(1)) ? '0 : WIDTH'(1);
          clken_next    = (pending_reg == WIDTH'(1));
          hold_cnt_next = '0;
          dp_reset_next = 1'b1;
          state_next    = S_HOLD;
        end
      end
      default: begin
        state_next = S_HOLD;
      end
    endcase
  end

  always_ff @(posedge fullclock or posedge reset) begin
    if (reset) begin
      state_reg    <= S_HOLD;
      cnt_reg      <= '0;
      hold_cnt_reg <= '0;
      pending_reg  <= '0;
      div_reg      <= RESET_DIV;
      clken_reg    <= 1'b0;
      dp_reset_reg <= 1'b1;
      ready_reg    <= 1'b0;
      running_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      hold_cnt_reg <= hold_cnt_next;
      pending_reg  <= pending_next;
      div_reg      <= div_next;
      clken_reg    <= clken_next;
      dp_reset_reg <= dp_reset_next;
      ready_reg    <= ready_next;
      running_reg  <= running_next;
    end
  end

  assign div_req_ready = ready_reg;
  assign active_div    = div_reg;
  assign clken         = clken_reg;
  assign dp_reset      = dp_reset_reg;
  assign running       = running_reg;

endmodule

// File: tb/tb_clken_sched.sv
// Randomised bench for clken_sched against a cycle-arithmetic model of pulse
// times, hold windows and handshake acceptance, plus literal timing pins.
module tb_clken_sched;
  localparam int W    = 8;
  localparam int RD   = 3;
  localparam int HOLD = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         div_req_valid;
  logic [W-1:0] div_req_value;
  logic         div_req_ready;
  logic [W-1:0] active_div;
  logic         clken;
  logic         dp_reset;
  logic         running;

  clken_sched #(.WIDTH(W), .DEFAULT_DIV(RD), .HOLD_PULSES(HOLD)) dut (
    .fullclock     (clk),
    .reset         (reset),
    .div_req_valid (div_req_valid),
    .div_req_value (div_req_value),
    .div_req_ready (div_req_ready),
    .active_div    (active_div),
    .clken         (clken),
    .dp_reset      (dp_reset),
    .running       (running)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Per-cycle log of DUT outputs for the literal pins of the current epoch.
  logic log_clk [0:255];
  logic log_dp  [0:255];
  logic log_rdy [0:255];
  int   log_div [0:255];

  task automatic chk(input string name, input int t, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, t, act, exp);
    end
  endtask

  // Model: origin s and divisor d define pulses at s+d, s+2d, ...; the hold
  // window is (s, s+HOLD*d]; an accepted request switches at the first pulse p>k.
  int m_s, m_d, m_k, m_new, m_p;
  bit m_acc, m_pf;

  always @(negedge clk) begin
    int t;
    bit e_clk, e_dp, e_rdy;
    if (reset) begin
      chk("rst_clken", 0, int'(clken), 0);
      chk("rst_dp_reset", 0, int'(dp_reset), 1);
      chk("rst_ready", 0, int'(div_req_ready), 0);
      chk("rst_running", 0, int'(running), 0);
      chk("rst_active_div", 0, int'(active_div), RD);
      m_s = 0; m_d = RD; m_acc = 0; m_pf = 0;
    end else if (cyc != 0) begin
      t = cyc;
      if (m_acc && m_pf && t == m_p + 1) begin
        m_s = m_p; m_d = m_new; m_acc = 0; m_pf = 0;
      end
      e_clk = (t > m_s) && ((t - m_s) % m_d == 0);
      if (m_acc && !m_pf && t > m_k && e_clk) begin
        m_pf = 1; m_p = t;
      end
      e_dp  = (t <= m_s + HOLD * m_d);
      e_rdy = !e_dp && !m_acc;
      chk("clken", t, int'(clken), int'(e_clk));
      chk("dp_reset", t, int'(dp_reset), int'(e_dp));
      chk("ready", t, int'(div_req_ready), int'(e_rdy));
      chk("running", t, int'(running), int'(e_rdy));
      chk("active_div", t, int'(active_div), m_d);
      if (t < 256) begin
        log_clk[t] = clken; log_dp[t] = dp_reset;
        log_rdy[t] = div_req_ready; log_div[t] = int'(active_div);
      end
      if (e_rdy && div_req_valid) begin
        m_acc = 1; m_k = t;
        m_new = (div_req_value == 0) ? 1 : int'(div_req_value);
        $display("cycle %0d: accept value=%0d -> div %0d", t, div_req_value, m_new);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!div_req_ready && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (!div_req_ready) begin
      errors++;
      $display("FAIL wait_ready cycle %0d: got ready=0 expected 1 within 3000 cycles", cyc);
    end
  endtask

  task automatic pins_startup();
    chk("pin_clken", 2, int'(log_clk[2]), 0);
    chk("pin_clken", 3, int'(log_clk[3]), 1);
    chk("pin_clken", 6, int'(log_clk[6]), 1);
    chk("pin_clken", 9, int'(log_clk[9]), 1);
    chk("pin_dp_reset", 48, int'(log_dp[48]), 1);
    chk("pin_dp_reset", 49, int'(log_dp[49]), 0);
    chk("pin_ready", 48, int'(log_rdy[48]), 0);
    chk("pin_ready", 49, int'(log_rdy[49]), 1);
  endtask

  initial begin
    reset = 1'b1;
    div_req_valid = 1'b0;
    div_req_value = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Startup and a request for 5 accepted in cycle 50.
    while (cyc < 50) tick();
    div_req_valid = 1'b1;
    div_req_value = 8'd5;
    tick();
    div_req_valid = 1'b0;
    while (cyc < 135) tick();
    pins_startup();
    chk("pin_active_div", 51, log_div[51], 3);
    chk("pin_active_div", 52, log_div[52], 5);
    chk("pin_clken", 51, int'(log_clk[51]), 1);
    chk("pin_clken", 55, int'(log_clk[55]), 0);
    chk("pin_clken", 56, int'(log_clk[56]), 1);
    chk("pin_clken", 61, int'(log_clk[61]), 1);
    chk("pin_dp_reset", 51, int'(log_dp[51]), 0);
    chk("pin_dp_reset", 52, int'(log_dp[52]), 1);
    chk("pin_dp_reset", 131, int'(log_dp[131]), 1);
    chk("pin_dp_reset", 132, int'(log_dp[132]), 0);

    // Request 0 clamps to 1.
    wait_ready();
    div_req_valid = 1'b1;
    div_req_value = 8'd0;
    tick();
    div_req_valid = 1'b0;
    repeat (60) tick();
    chk("pin_active_div_clamped", cyc, int'(active_div), 1);

    // Switch to 4, then accept in a cycle that carries a pulse.
    wait_ready();
    div_req_valid = 1'b1;
    div_req_value = 8'd4;
    tick();
    div_req_valid = 1'b0;
    wait_ready();
    for (int i = 0; i < 20 && !clken; i++) tick();
    div_req_valid = 1'b1;
    div_req_value = 8'd6;
    tick();
    div_req_valid = 1'b0;
    repeat (40) tick();

    // Valid held high across HOLD phases with changing values.
    div_req_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      div_req_value = W'($urandom_range(0, 6));
      tick();
    end
    div_req_valid = 1'b0;

    // Reset while draining with 7 pending.
    wait_ready();
    div_req_valid = 1'b1;
    div_req_value = 8'd7;
    tick();
    div_req_valid = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    while (cyc < 60) tick();
    pins_startup();

    // Random traffic with occasional resets.
    for (int i = 0; i < 8000; i++) begin
      div_req_valid = ($urandom_range(0, 2) == 0);
      div_req_value = W'($urandom_range(0, 9));
      if ($urandom_range(0, 1499) == 0) reset = 1'b1;
      tick();
      reset = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
